// File: rtl/saturn_phase_ctrl.sv
// saturn_phase_ctrl: four-phase sequencer for the Saturn core.
// Generates per-phase enables for the ALU, fetch unit and decoder. It also
// handles the post-reset start-up delay, halt/single-step debug control and
// cycle/stall accounting.
// Optional feature macro: SATURN_PHASE_CTR_EN (cycle and stall counters).
//
// state | meaning
// WAIT  | start-up delay after reset, dly_cnt counting down
// RUN   | free-running phase sequence, halt checked at each cycle boundary
// HALT  | debug halt, phase parked at 0, all enables low
// STEP  | one full instruction cycle while halted, then back to HALT
module saturn_phase_ctrl #(
  parameter int unsigned RESET_DLY = 4,
  parameter int unsigned CTR_W     = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_halt_req,
  input  logic             i_step,
  input  logic             i_alu_stall_dec,
  input  logic             i_ctr_clr,
  output logic [1:0]       o_phase,
  output logic             o_en_alu_dump,
  output logic             o_en_fetch,
  output logic             o_en_alu_prep,
  output logic             o_en_alu_calc,
  output logic             o_en_dec,
  output logic             o_en_alu_init,
  output logic             o_en_alu_save,
  output logic             o_halted,
  output logic [CTR_W-1:0] o_cycle_ctr,
  output logic [CTR_W-1:0] o_stall_ctr
);

  typedef enum logic [1:0] {
    ST_WAIT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2,
    ST_STEP = 2'd3
  } state_t;

  state_t     st;
  logic [1:0] phase;
  logic [7:0] dly_cnt;
  logic       active;
  logic       last_phase;

  assign active     = (st == ST_RUN) || (st == ST_STEP);
  assign last_phase = (phase == 2'd3);

  // Sequencer: start-up delay, phase rotation and halt/step control.
  // A cycle, once started, always runs to its phase-3 edge.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      st      <= ST_WAIT;
      phase   <= 2'd0;
      dly_cnt <= 8'(RESET_DLY);
    end else begin
      case (st)
        ST_WAIT: begin
          if (dly_cnt == 8'd0) st <= ST_RUN;
          else                 dly_cnt <= dly_cnt - 8'd1;
        end
        ST_RUN: begin
          phase <= phase + 2'd1;
          if (last_phase && i_halt_req) st <= ST_HALT;
        end
        ST_STEP: begin
          phase <= phase + 2'd1;
          if (last_phase) st <= ST_HALT;
        end
        ST_HALT: begin
          phase <= 2'd0;
          if (!i_halt_req) st <= ST_RUN;
          else if (i_step) st <= ST_STEP;
        end
        default: st <= ST_WAIT;
      endcase
    end
  end

  // Enables decode straight from the registered state so reset drops them at once.
  // Fetch and decode additionally respect the ALU stall.
  assign o_phase       = phase;
  assign o_en_alu_dump = active && (phase == 2'd0);
  assign o_en_alu_prep = active && (phase == 2'd1);
  assign o_en_fetch    = active && (phase == 2'd1) && !i_alu_stall_dec;
  assign o_en_alu_calc = active && (phase == 2'd2);
  assign o_en_dec      = active && (phase == 2'd2) && !i_alu_stall_dec;
  assign o_en_alu_init = active && last_phase;
  assign o_en_alu_save = active && last_phase;
  assign o_halted      = (st == ST_HALT);

`ifdef SATURN_PHASE_CTR_EN
  logic [CTR_W-1:0] cycle_ctr;
  logic [CTR_W-1:0] stall_ctr;

  // Accounting at each completed active cycle; clear wins over increment.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      cycle_ctr <= '0;
      stall_ctr <= '0;
    end else if (i_ctr_clr) begin
      cycle_ctr <= '0;
      stall_ctr <= '0;
    end else if (active && last_phase) begin
      cycle_ctr <= cycle_ctr + CTR_W'(1);
      if (i_alu_stall_dec) stall_ctr <= stall_ctr + CTR_W'(1);
    end
  end

  assign o_cycle_ctr = cycle_ctr;
  assign o_stall_ctr = stall_ctr;
`else
  logic unused_ctr_clr;

  assign unused_ctr_clr = i_ctr_clr;
  assign o_cycle_ctr    = '0;
  assign o_stall_ctr    = '0;
`endif

endmodule

// File: tb/tb_saturn_phase_ctrl.sv
// tb_saturn_phase_ctrl: directed scenarios plus random stimulus for
// saturn_phase_ctrl, compared against a behavioural model of the sequencer.
module tb_saturn_phase_ctrl;
  localparam int unsigned RESET_DLY = 4;
  localparam int unsigned CTR_W     = 5;

  logic             i_clk = 1'b0;
  logic             i_reset = 1'b1;
  logic             i_halt_req = 1'b0;
  logic             i_step = 1'b0;
  logic             i_alu_stall_dec = 1'b0;
  logic             i_ctr_clr = 1'b0;
  logic [1:0]       o_phase;
  logic             o_en_alu_dump, o_en_fetch, o_en_alu_prep, o_en_alu_calc;
  logic             o_en_dec, o_en_alu_init, o_en_alu_save, o_halted;
  logic [CTR_W-1:0] o_cycle_ctr, o_stall_ctr;

  saturn_phase_ctrl #(.RESET_DLY(RESET_DLY), .CTR_W(CTR_W)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_halt_req(i_halt_req), .i_step(i_step),
    .i_alu_stall_dec(i_alu_stall_dec), .i_ctr_clr(i_ctr_clr), .o_phase(o_phase),
    .o_en_alu_dump(o_en_alu_dump), .o_en_fetch(o_en_fetch), .o_en_alu_prep(o_en_alu_prep),
    .o_en_alu_calc(o_en_alu_calc), .o_en_dec(o_en_dec), .o_en_alu_init(o_en_alu_init),
    .o_en_alu_save(o_en_alu_save), .o_halted(o_halted), .o_cycle_ctr(o_cycle_ctr),
    .o_stall_ctr(o_stall_ctr)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: boot countdown, then instruction cycles of four phases.
  // Halt requests are honoured only when a cycle completes.
  int  m_boot_left;
  bit  m_booted;
  bit  m_halted;
  bit  m_stepping;
  int  m_pos;
  int  m_cyc;
  int  m_stl;
  localparam int CTR_MOD = 1 << CTR_W;

  task automatic model_reset();
    m_boot_left = RESET_DLY; m_booted = 0; m_halted = 0; m_stepping = 0;
    m_pos = 0; m_cyc = 0; m_stl = 0;
  endtask

  task automatic model_edge(input bit h, input bit s, input bit st, input bit c);
    if (!m_booted) begin
      if (m_boot_left == 0) m_booted = 1;
      else m_boot_left--;
    end else if (m_halted) begin
      if (!h) m_halted = 0;
      else if (s) begin m_halted = 0; m_stepping = 1; end
    end else begin
      if (m_pos == 3) begin
        m_cyc = (m_cyc + 1) % CTR_MOD;
        if (st) m_stl = (m_stl + 1) % CTR_MOD;
        if (m_stepping || h) begin m_halted = 1; m_stepping = 0; end
      end
      m_pos = (m_pos + 1) % 4;
    end
    if (c) begin m_cyc = 0; m_stl = 0; end
  endtask

  function automatic logic [6:0] exp_en(input bit st);
    bit act;
    act = m_booted && !m_halted;
    if (!act) return 7'b0;
    return {m_pos == 0, m_pos == 1 && !st, m_pos == 1, m_pos == 2,
            m_pos == 2 && !st, m_pos == 3, m_pos == 3};
  endfunction

  function automatic logic [31:0] exp_ctr(input int v);
`ifdef SATURN_PHASE_CTR_EN
    return 32'(v);
`else
    return 32'(v * 0);
`endif
  endfunction

  task automatic compare_outputs();
    chk("phase", 32'(o_phase), 32'(m_pos));
    chk("enables", 32'({o_en_alu_dump, o_en_fetch, o_en_alu_prep, o_en_alu_calc,
                        o_en_dec, o_en_alu_init, o_en_alu_save}), 32'(exp_en(i_alu_stall_dec)));
    chk("halted", 32'(o_halted), 32'(m_halted));
    chk("cycle_ctr", 32'(o_cycle_ctr), exp_ctr(m_cyc));
    chk("stall_ctr", 32'(o_stall_ctr), exp_ctr(m_stl));
  endtask

  function automatic logic [31:0] all_outputs();
    return 32'({o_phase, o_en_alu_dump, o_en_fetch, o_en_alu_prep, o_en_alu_calc,
                o_en_dec, o_en_alu_init, o_en_alu_save, o_halted, o_cycle_ctr, o_stall_ctr});
  endfunction

  // Called at a falling edge: drive inputs, check, take one rising edge.
  task automatic tick(input bit h, input bit s, input bit st, input bit c);
    i_halt_req = h; i_step = s; i_alu_stall_dec = st; i_ctr_clr = c;
    #1;
    compare_outputs();
    @(posedge i_clk);
    model_edge(h, s, st, c);
    @(negedge i_clk);
  endtask

  // Assert reset between edges, check the asynchronous drop, release after one edge.
  task automatic do_reset(input string tag);
    i_reset = 1'b1; i_step = 1'b0; i_ctr_clr = 1'b0;
    #1;
    chk(tag, all_outputs(), 32'd0);
    @(posedge i_clk);
    @(negedge i_clk);
    i_reset = 1'b0;
    model_reset();
  endtask

  int  first_dump;
  int  n;
  bit  rh;

  initial begin
    model_reset();
    @(negedge i_clk);

    // Start-up delay: first dump strobe after edge RESET_DLY+1.
    do_reset("reset_outputs");
    first_dump = -1;
    for (int k = 1; k <= 10; k++) begin
      tick(0, 0, 0, 0);
      if (o_en_alu_dump && first_dump < 0) first_dump = k;
    end
    chk("first_dump_edge", 32'(first_dump), 32'(RESET_DLY + 1));

    // Stall held for three full cycles.
    do_reset("reset_outputs2");
    for (int k = 0; k < 5; k++) tick(0, 0, 0, 0);
    for (int k = 0; k < 12; k++) tick(0, 0, 1, 0);
    chk("stall_cycle_ctr", 32'(o_cycle_ctr), exp_ctr(3));
    chk("stall_stall_ctr", 32'(o_stall_ctr), exp_ctr(3));

    // Halt raised in phase 1 completes the cycle, then halts.
    tick(0, 0, 0, 0);
    tick(1, 0, 0, 0);
    tick(1, 0, 0, 0);
    tick(1, 0, 0, 0);
    chk("halt_after_cycle", 32'(o_halted), 32'd1);
    tick(1, 0, 0, 0);
    tick(0, 0, 0, 0);
    chk("resume_dump", 32'({o_phase, o_en_alu_dump, o_halted}), 32'b00_1_0);

    // Single step: one full cycle then back to HALT.
    n = 0;
    while (!m_halted && n < 16) begin tick(1, 0, 0, 0); n++; end
    chk("halt_reached", 32'(o_halted), 32'd1);
    tick(1, 1, 0, 0);
    n = 0;
    for (int k = 0; k < 4; k++) begin
      n += int'(o_en_alu_dump) + int'(o_en_alu_prep) + int'(o_en_alu_calc) + int'(o_en_alu_save);
      tick(1, 0, 0, 0);
    end
    chk("step_strobes", 32'(n), 32'd4);
    chk("halted_after_step", 32'(o_halted), 32'd1);
    tick(0, 0, 0, 0);
    for (int k = 0; k < 6; k++) tick(0, 1, 0, 0);

    // Reset during phase 2.
    n = 0;
    while (m_pos != 2 && n < 8) begin tick(0, 0, 1, 0); n++; end
    do_reset("reset_mid_cycle");

    // Counter wrap after 2^CTR_W cycles, then clear on a phase-3 edge.
    for (int k = 0; k < 5; k++) tick(0, 0, 0, 0);
    for (int k = 0; k < 4 * CTR_MOD; k++) tick(0, 0, 1, 0);
    chk("cycle_wrap", 32'(o_cycle_ctr), 32'd0);
    tick(0, 0, 1, 0); tick(0, 0, 1, 0); tick(0, 0, 1, 0);
    tick(0, 0, 1, 1);
    chk("clr_priority", 32'({o_cycle_ctr, o_stall_ctr}), 32'd0);

    // Random stimulus.
    rh = 0;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(19) == 0) rh = ~rh;
      if ($urandom_range(599) == 0) do_reset("reset_random");
      else tick(rh, $urandom_range(7) == 0, $urandom_range(2) == 0, $urandom_range(99) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end
endmodule
